sobel_window_gen: RTL and testbench
===================================

# sobel_window_gen

Upstream neighbour of the `Sobel` core: accepts a raster-order pixel stream (one 8-bit pixel per accepted beat) and presents a full 3x3 neighbourhood plus centre coordinates to the gradient stage. Two internal line buffers hold the previous two rows. Windows are emitted only for interior centres, so the downstream stage never handles border pixels.

## Interface
- `WIDTH`, 256, pixels per row (>=3)
- `HEIGHT`, 256, rows per frame (>=3)
- `CW`, 8, coordinate width, equal to clog2(max(WIDTH,HEIGHT))
- `CLK`  in  1  clock, rising-edge
- `RST_n`  in  1  reset, asynchronous, active-low
- `Start`  in  1  frame start request, level
- `DataIn`  in  8  input pixel
- `DinValid`  in  1  DataIn valid this cycle
- `Window`  out  72  3x3 window; pixel (i,j) at bits [8*(3i+j)+7 : 8*(3i+j)], i=0 top row, j=0 left column
- `WinValid`  out  1  Window, Out_Row, Out_Column valid this cycle
- `Out_Row`  out  CW  centre row of current window
- `Out_Column`  out  CW  centre column of current window
- `isBusy`  out  1  state is FILL or STREAM
- `Finish`  out  1  frame complete, held in DONE
- `debug_current_state`  out  2  IDLE=0, FILL=1, STREAM=2, DONE=3

## Operation
- Accept condition: `DinValid` && state in {FILL, STREAM}. DinValid is ignored in IDLE/DONE.
- Counters `r` (row) and `c` (col) give the position of the next accepted pixel.
  - On accept: c increments.
  - c==WIDTH-1 wraps to 0 and r increments.
- Line buffers: `lbA` holds row r-1 and `lbB` holds row r-2, each WIDTH x 8. On accept of pixel p at column c:
  - read top=lbB[c], mid=lbA[c];
  - write lbB[c]<=lbA[c], lbA[c]<=p;
  - shift window columns left (col0<=col1, col1<=col2);
  - load col2<={top, mid, p}.
- Window valid: if the accepted pixel has r>=2 and c>=2, then next cycle WinValid=1, Out_Row=r-1, Out_Column=c-1. Otherwise WinValid=0.
- Stale columns carried over from the previous row are never flagged valid, because c>=2 is required.
- FSM:
  - IDLE: Start=1 -> FILL; r, c cleared on entry.
  - FILL: after the accept at r=1, c=WIDTH-1 -> STREAM.
  - STREAM: after the accept at r=HEIGHT-1, c=WIDTH-1 -> DONE.
  - DONE: Finish=1; Start=0 -> IDLE; Start held high stays in DONE.
- Start while FILL/STREAM is ignored. A pixel presented in the same cycle IDLE sees Start is not accepted.
- Windows per frame: (HEIGHT-2)(WIDTH-2); 64516 at defaults.

## Timing
- Reset values (async, immediate on RST_n=0):
  - state=IDLE, r=c=0;
  - Window=0, WinValid=0, Out_Row=0, Out_Column=0, isBusy=0, Finish=0.
  - Line buffer contents are not cleared.
- Reset mid-frame aborts the frame. A new frame needs a fresh Start after RST_n returns high.
- Latency: accept edge -> WinValid/Window registered output 1 cycle later; WinValid is a single-cycle pulse per qualifying accept.
- Input gaps (DinValid=0): counters, buffers and window hold; WinValid=0.
- No backpressure: the downstream stage must consume every WinValid beat.
- Last window: WinValid rises in the same cycle Finish first rises (first DONE cycle).
- isBusy falls in the same cycle Finish rises.
- Output fields are registered; with WinValid=0 they hold their last values.

## Test plan
- WIDTH=HEIGHT=4, pixel value 4r+c, continuous DinValid after Start:
  - exactly 4 windows, centres (1,1), (1,2), (2,1), (2,2);
  - first window rows = {0,1,2}, {4,5,6}, {8,9,10}, arriving 1 cycle after pixel 10 is accepted;
  - Finish=1 together with the last window, whose bottom-right pixel is 15.
- Same frame with DinValid deasserted on every other cycle:
  - identical window sequence, values and count;
  - no WinValid in gap-following cycles without an accept.
- Assert RST_n=0 after pixel 9:
  - all outputs 0 immediately, state 0;
  - Start then the full 16-pixel frame gives the same 4 windows as a clean run.
- Pulse Start and drive DinValid during STREAM:
  - state does not return to FILL; window count unchanged.
  - Hold Start=1 after Finish: state stays 3.
  - Drop Start: state 0 the next cycle and Finish=0.
- Default 256x256 frame from Matrix_binary.txt:
  - exactly 64516 WinValid pulses;
  - Out_Row/Out_Column sweep 1..254;
  - Window matches the 3x3 neighbourhood from a software model at every pulse.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle between the raster source, the window generator
// and the downstream gradient stage.
interface sobel_window_gen_if #(
  parameter int unsigned CW = 8
);
  logic          Start;
  logic [7:0]    DataIn;
  logic          DinValid;
  logic [71:0]   Window;
  logic          WinValid;
  logic [CW-1:0] Out_Row;
  logic [CW-1:0] Out_Column;
  logic          isBusy;
  logic          Finish;
  logic [1:0]    debug_current_state;

  modport master (
    output Start, DataIn, DinValid,
    input  Window, WinValid, Out_Row, Out_Column, isBusy, Finish, debug_current_state
  );

  modport slave (
    input  Start, DataIn, DinValid,
    output Window, WinValid, Out_Row, Out_Column, isBusy, Finish, debug_current_state
  );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a sliding column window,
// emitting registered windows only for interior centre pixels.
module sobel_window_gen #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned CW     = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT)
) (
  input  logic             CLK,
  input  logic             RST_n,
  sobel_window_gen_if.slave bus
);
  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  // Two most recent columns; element [0] is the top row
  logic [2:0][7:0] colm_q, colm_d, coln_q, coln_d, col_new;
  logic [71:0]   win_q, win_d, win_next;
  logic          vld_q, vld_d;
  logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic          busy_q, busy_d, fin_q, fin_d;
  logic          accept, last_col;
  logic [AW-1:0] lb_idx;

  logic [7:0] lb_a [WIDTH];
  logic [7:0] lb_b [WIDTH];

  assign accept   = bus.DinValid && ((state_q == FILL) || (state_q == STREAM));
  assign last_col = (c_q == CW'(WIDTH - 1));
  assign lb_idx   = c_q[AW-1:0];
  assign col_new  = {bus.DataIn, lb_a[lb_idx], lb_b[lb_idx]};

  // Window as it stands after this accept: old col1, old col2, new column
  always_comb begin
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      win_next[8*(3*i+0) +: 8] = colm_q[i];
      win_next[8*(3*i+1) +: 8] = coln_q[i];
      win_next[8*(3*i+2) +: 8] = col_new[i];
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    colm_d  = colm_q;
    coln_d  = coln_q;
    win_d   = win_q;
    vld_d   = 1'b0;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    case (state_q)
      IDLE:   if (bus.Start) begin
                state_d = FILL;
                r_d     = '0;
                c_d     = '0;
              end
      FILL:   if (accept && (r_q == CW'(1)) && last_col) state_d = STREAM;
      STREAM: if (accept && (r_q == CW'(HEIGHT - 1)) && last_col) state_d = DONE;
      DONE:   if (!bus.Start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      c_d    = last_col ? '0 : c_q + CW'(1);
      r_d    = last_col ? r_q + CW'(1) : r_q;
      colm_d = coln_q;
      coln_d = col_new;
      if ((r_q >= CW'(2)) && (c_q >= CW'(2))) begin
        vld_d  = 1'b1;
        orow_d = r_q - CW'(1);
        ocol_d = c_q - CW'(1);
        win_d  = win_next;
      end
    end
    busy_d = (state_d == FILL) || (state_d == STREAM);
    fin_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      colm_q  <= '0;
      coln_q  <= '0;
      win_q   <= '0;
      vld_q   <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      colm_q  <= colm_d;
      coln_q  <= coln_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  // Line buffers are plain storage; contents survive reset
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb_b[lb_idx] <= lb_a[lb_idx];
      lb_a[lb_idx] <= bus.DataIn;
    end
  end

  assign bus.Window              = win_q;
  assign bus.WinValid            = vld_q;
  assign bus.Out_Row             = orow_q;
  assign bus.Out_Column          = ocol_q;
  assign bus.isBusy              = busy_q;
  assign bus.Finish              = fin_q;
  assign bus.debug_current_state = state_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 frame: scoreboard of
// model windows plus a table of hand-derived windows for the 4r+c frame.
module tb_sobel_window_gen;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned CW = 2;

  typedef struct {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [71:0]   win;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_n;
  always #5 CLK = ~CLK;

  sobel_window_gen_if #(.CW(CW)) bus ();

  sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  exp_t tbl[4];
  logic [7:0] img [H][W];

  int win_cnt = 0;
  logic [71:0]     cap    [64];
  logic [2*CW-1:0] cap_rc [64];

  always @(negedge CLK) begin
    if (RST_n === 1'b1 && bus.WinValid === 1'b1) begin
      cap[win_cnt % 64]    <= bus.Window;
      cap_rc[win_cnt % 64] <= {bus.Out_Row, bus.Out_Column};
      win_cnt              <= win_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] model_win(input int row, input int col);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = img[row-1+i][col-1+j];
    return w;
  endfunction

  function automatic logic [71:0] ramp_win(input int row, input int col);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(4 * (row - 1 + i) + (col - 1 + j));
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_window"}, bus.Window, 72'd0);
    check({tag, "_winvalid"}, 72'(bus.WinValid), 72'd0);
    check({tag, "_row"}, 72'(bus.Out_Row), 72'd0);
    check({tag, "_col"}, 72'(bus.Out_Column), 72'd0);
    check({tag, "_busy"}, 72'(bus.isBusy), 72'd0);
    check({tag, "_finish"}, 72'(bus.Finish), 72'd0);
    check({tag, "_state"}, 72'(bus.debug_current_state), 72'd0);
  endtask

  task automatic run_frame(input bit gap, input int pulse_idx, input bit hold,
                           input int abort_idx, input bit rnd, output int base);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rnd ? 8'($urandom) : 8'(4 * r + c);
    base = win_cnt;
    // A pixel alongside Start in IDLE must not be taken
    bus.Start    = 1'b1;
    bus.DinValid = 1'b1;
    bus.DataIn   = 8'hAA;
    @(negedge CLK);
    bus.Start    = 1'b0;
    bus.DinValid = 1'b0;
    check("state_fill", 72'(bus.debug_current_state), 72'd1);
    check("busy_on", 72'(bus.isBusy), 72'd1);
    for (int k = 0; k < W * H; k++) begin
      int r;
      int c;
      bit qual;
      r = k / W;
      c = k % W;
      qual = (r >= 2) && (c >= 2);
      if (gap && k > 0) begin
        bus.DinValid = 1'b0;
        bus.DataIn   = 8'h55;
        @(negedge CLK);
        check("gap_no_valid", 72'(bus.WinValid), 72'd0);
      end
      bus.DataIn   = img[r][c];
      bus.DinValid = 1'b1;
      bus.Start    = (k == pulse_idx);
      if (qual) begin
        e.row = CW'(r - 1);
        e.col = CW'(c - 1);
        e.win = model_win(r - 1, c - 1);
        sb.push_back(e);
      end
      @(negedge CLK);
      bus.Start = 1'b0;
      check("valid_pulse", 72'(bus.WinValid), 72'(qual));
      if (bus.WinValid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_row", 72'(bus.Out_Row), 72'(e.row));
        check("sb_col", 72'(bus.Out_Column), 72'(e.col));
        check("sb_window", bus.Window, e.win);
      end
      if (k == pulse_idx) check("start_ignored", 72'(bus.debug_current_state), 72'd2);
      if (k == abort_idx) begin
        bus.DinValid = 1'b0;
        #2 RST_n = 1'b0;
        #1 check_all_zero("abort");
        sb.delete();
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        return;
      end
    end
    bus.DinValid = 1'b0;
    check("finish_last", 72'(bus.Finish), 72'd1);
    check("busy_off", 72'(bus.isBusy), 72'd0);
    check("state_done", 72'(bus.debug_current_state), 72'd3);
    if (hold) begin
      bus.Start    = 1'b1;
      bus.DinValid = 1'b1;
      repeat (3) begin
        @(negedge CLK);
        check("hold_state", 72'(bus.debug_current_state), 72'd3);
        check("hold_finish", 72'(bus.Finish), 72'd1);
        check("hold_no_valid", 72'(bus.WinValid), 72'd0);
      end
      bus.Start    = 1'b0;
      bus.DinValid = 1'b0;
    end
    @(negedge CLK);
    check("back_idle", 72'(bus.debug_current_state), 72'd0);
    check("finish_clear", 72'(bus.Finish), 72'd0);
    @(negedge CLK);
    check("win_count", 72'(win_cnt - base), 72'((H - 2) * (W - 2)));
  endtask

  task automatic check_table(input int base);
    for (int k = 0; k < 4; k++) begin
      check("tbl_window", cap[(base + k) % 64], tbl[k].win);
      check("tbl_rc", 72'(cap_rc[(base + k) % 64]), 72'({tbl[k].row, tbl[k].col}));
    end
  endtask

  initial begin
    int base;
    logic [71:0] w;
    tbl[0] = '{row: CW'(1), col: CW'(1), win: ramp_win(1, 1)};
    tbl[1] = '{row: CW'(1), col: CW'(2), win: ramp_win(1, 2)};
    tbl[2] = '{row: CW'(2), col: CW'(1), win: ramp_win(2, 1)};
    tbl[3] = '{row: CW'(2), col: CW'(2), win: ramp_win(2, 2)};

    RST_n        = 1'b0;
    bus.Start    = 1'b0;
    bus.DinValid = 1'b0;
    bus.DataIn   = 8'h00;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST_n = 1'b1;
    @(negedge CLK);

    run_frame(1'b0, -1, 1'b0, -1, 1'b0, base);
    check_table(base);
    w = cap[base % 64];
    check("first_br_pixel", 72'(w[71:64]), 72'd10);
    check("first_tl_pixel", 72'(w[7:0]), 72'd0);
    w = cap[(base + 3) % 64];
    check("last_br_pixel", 72'(w[71:64]), 72'd15);

    run_frame(1'b1, -1, 1'b0, -1, 1'b0, base);
    check_table(base);

    run_frame(1'b0, -1, 1'b0, 9, 1'b0, base);
    run_frame(1'b0, -1, 1'b0, -1, 1'b0, base);
    check_table(base);

    run_frame(1'b0, 10, 1'b1, -1, 1'b0, base);
    run_frame(1'b0, -1, 1'b0, -1, 1'b1, base);
    run_frame(1'b1, -1, 1'b1, -1, 1'b1, base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
